// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// BP_META_WIDTH sets the predictor metadata width (defaults to 8).
`ifndef BP_META_WIDTH
`define BP_META_WIDTH 8
`endif

package fetch_pkg;

    localparam int BP_META_W = `BP_META_WIDTH;
    localparam int FETCH_Q_DEPTH = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [31:0]          p_target;
        logic                 p_dir;
        logic [BP_META_W-1:0] meta;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry circular buffer between fetch and decode.
// Flush wins over both push and pop in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type T = fetch_bundle_t
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  T           din,
    output T           head,
    output logic       valid,
    output logic [1:0] count
);

    logic [1:0] cnt;
    logic       hd;
    logic       tl;
    T           mem [FETCH_Q_DEPTH];
    logic       do_pop;
    logic       do_push;

    assign do_pop  = pop & ~flush & (cnt != 2'd0);
    // A full queue still accepts a push when the head leaves together.
    assign do_push = push & ~flush & ((cnt < 2'd2) | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 2'd0;
            hd     <= 1'b0;
            tl     <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
            hd  <= 1'b0;
            tl  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[tl] <= din;
                tl      <= ~tl;
            end
            if (do_pop) begin
                hd <= ~hd;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[hd];
    assign valid = (cnt != 2'd0);
    assign count = cnt;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, steers BRAM reads, queues bundles to decode.
// FETCH_PERF_CNT_EN builds the fetch/stall performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          IC_ADDR_W = 8,
    parameter int          META_W    = BP_META_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [IC_ADDR_W-1:0] ic_rdaddress,
    input  logic [31:0]          ic_q,
    output logic [31:0]          fetch_bpredictor_PC,
    output logic [31:0]          fetch_bpredictor_inst,
    output logic                 fetch_bpredictor_stall,
    input  logic [31:0]          bpredictor_fetch_p_target,
    input  logic                 bpredictor_fetch_p_dir,
    input  logic [META_W-1:0]    bpredictor_fetch_meta,
    input  logic                 execute_fetch_redirect,
    input  logic [31:0]          execute_fetch_redirect_PC,
    output logic                 fetch_decode_valid,
    output logic [31:0]          fetch_decode_PC,
    output logic [31:0]          fetch_decode_inst,
    output logic [31:0]          fetch_decode_p_target,
    output logic                 fetch_decode_p_dir,
    output logic [META_W-1:0]    fetch_decode_meta,
    input  logic                 decode_fetch_ready,
    output logic [31:0]          fetch_count,
    output logic [31:0]          stall_count
);

    logic [31:0]   pc_f1;
    logic          f1_valid;
    logic [31:0]   next_pc;
    logic          advance;
    logic          deq;
    logic [1:0]    q_count;
    fetch_bundle_t q_din;
    fetch_bundle_t q_head;

    assign deq     = fetch_decode_valid & decode_fetch_ready;
    assign advance = f1_valid & ((q_count < 2'd2) | deq)
                   & ~execute_fetch_redirect;

    always_comb begin
        next_pc = pc_f1;
        unique case (1'b1)
            execute_fetch_redirect: next_pc = execute_fetch_redirect_PC;
            advance:                next_pc = bpredictor_fetch_p_target;
            default:                next_pc = pc_f1;
        endcase
    end

    // A stalled F1 re-reads its own PC so ic_q stays valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_f1    <= RESET_PC;
            f1_valid <= 1'b0;
        end else begin
            pc_f1    <= next_pc;
            f1_valid <= 1'b1;
        end
    end

    assign ic_rdaddress           = next_pc[IC_ADDR_W+1:2];
    assign fetch_bpredictor_PC    = pc_f1;
    assign fetch_bpredictor_inst  = ic_q;
    assign fetch_bpredictor_stall = ~advance;

    always_comb begin
        q_din          = '0;
        q_din.pc       = pc_f1;
        q_din.inst     = ic_q;
        q_din.p_target = bpredictor_fetch_p_target;
        q_din.p_dir    = bpredictor_fetch_p_dir;
        q_din.meta     = bpredictor_fetch_meta;
    end

    fetch_queue #(
        .T(fetch_bundle_t)
    ) u_queue (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (advance),
        .pop    (deq),
        .flush  (execute_fetch_redirect),
        .din    (q_din),
        .head   (q_head),
        .valid  (fetch_decode_valid),
        .count  (q_count)
    );

    assign fetch_decode_PC       = q_head.pc;
    assign fetch_decode_inst     = q_head.inst;
    assign fetch_decode_p_target = q_head.p_target;
    assign fetch_decode_p_dir    = q_head.p_dir;
    assign fetch_decode_meta     = q_head.meta;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt;
    logic [31:0] scnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt <= 32'd0;
            scnt <= 32'd0;
        end else begin
            if (advance) begin
                fcnt <= fcnt + 32'd1;
            end
            if (f1_valid & ~advance & ~execute_fetch_redirect) begin
                scnt <= scnt + 32'd1;
            end
        end
    end

    assign fetch_count = fcnt;
    assign stall_count = scnt;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: BRAM and predictor models plus fixed steps.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic [7:0]  ic_rdaddress;
    logic [31:0] ic_q;
    logic [31:0] bp_pc;
    logic [31:0] bp_inst;
    logic        bp_stall;
    logic [31:0] p_target;
    logic        p_dir;
    logic [7:0]  meta;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic [31:0] d_pc;
    logic [31:0] d_inst;
    logic [31:0] d_target;
    logic        d_dir;
    logic [7:0]  d_meta;
    logic        ready;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_fc;
    logic [31:0] exp_sc;

    fetch_stage dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .ic_rdaddress             (ic_rdaddress),
        .ic_q                     (ic_q),
        .fetch_bpredictor_PC      (bp_pc),
        .fetch_bpredictor_inst    (bp_inst),
        .fetch_bpredictor_stall   (bp_stall),
        .bpredictor_fetch_p_target(p_target),
        .bpredictor_fetch_p_dir   (p_dir),
        .bpredictor_fetch_meta    (meta),
        .execute_fetch_redirect   (redirect),
        .execute_fetch_redirect_PC(redirect_pc),
        .fetch_decode_valid       (valid),
        .fetch_decode_PC          (d_pc),
        .fetch_decode_inst        (d_inst),
        .fetch_decode_p_target    (d_target),
        .fetch_decode_p_dir       (d_dir),
        .fetch_decode_meta        (d_meta),
        .decode_fetch_ready       (ready),
        .fetch_count              (fetch_count),
        .stall_count              (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM returns a PC-tagged word one cycle after the address.
    always @(posedge clk) ic_q <= 32'hA500_0000 | {22'd0, ic_rdaddress, 2'b00};

    // Predictor: PC+4, except a taken branch at 0x8 to 0x40.
    always_comb begin
        p_dir    = (bp_pc == 32'h8);
        p_target = p_dir ? 32'h40 : bp_pc + 32'd4;
        meta     = bp_pc[7:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b1;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1 reset_n = 1'b0;
        step(2);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_stall", {31'd0, bp_stall}, 32'd1);
        chk("rst_rdaddr", {24'd0, ic_rdaddress}, 32'd0);
        chk("rst_bp_pc", bp_pc, 32'h0);
        chk("rst_d_pc", d_pc, 32'h0);
        chk("rst_d_inst", d_inst, 32'h0);
        chk("rst_fcnt", fetch_count, 32'd0);
        chk("rst_scnt", stall_count, 32'd0);

        // Streaming with a taken branch at 0x8.
        reset_n = 1'b1;
        step(1);
        chk("e1_valid", {31'd0, valid}, 32'd0);
        chk("e1_stall", {31'd0, bp_stall}, 32'd0);
        step(1);
        chk("e2_valid", {31'd0, valid}, 32'd1);
        chk("e2_pc", d_pc, 32'h0);
        chk("e2_inst", d_inst, 32'hA500_0000);
        step(1);
        chk("e3_pc", d_pc, 32'h4);
        chk("e3_tgt", d_target, 32'h8);
        step(1);
        chk("e4_pc", d_pc, 32'h8);
        chk("e4_dir", {31'd0, d_dir}, 32'd1);
        chk("e4_tgt", d_target, 32'h40);
        chk("e4_meta", {24'd0, d_meta}, 32'h8);
        step(1);
        chk("e5_valid", {31'd0, valid}, 32'd1);
        chk("e5_pc", d_pc, 32'h40);
        chk("e5_dir", {31'd0, d_dir}, 32'd0);
        step(1);
        chk("e6_pc", d_pc, 32'h44);
        chk("e6_stall", {31'd0, bp_stall}, 32'd0);

        // Decode back-pressure for five cycles.
        ready = 1'b0;
        step(1);
        chk("bp1_stall", {31'd0, bp_stall}, 32'd1);
        chk("bp1_bppc", bp_pc, 32'h4C);
        chk("bp1_rdaddr", {24'd0, ic_rdaddress}, 32'h13);
        step(4);
        chk("bp5_valid", {31'd0, valid}, 32'd1);
        chk("bp5_pc", d_pc, 32'h44);
        chk("bp5_stall", {31'd0, bp_stall}, 32'd1);
        chk("bp5_rdaddr", {24'd0, ic_rdaddress}, 32'h13);
        chk("bp5_inst_f1", bp_inst, 32'hA500_004C);
        ready = 1'b1;
        step(1);
        chk("rl1_pc", d_pc, 32'h48);
        step(1);
        chk("rl2_pc", d_pc, 32'h4C);
        chk("rl2_inst", d_inst, 32'hA500_004C);
        step(1);
        chk("rl3_pc", d_pc, 32'h50);

        // Redirect with a full queue and decode ready.
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("rd_stall", {31'd0, bp_stall}, 32'd1);
        chk("rd_rdaddr", {24'd0, ic_rdaddress}, 32'h40);
        step(1);
        redirect = 1'b0;
        #1;
        chk("rd_valid_lo", {31'd0, valid}, 32'd0);
        chk("rd_bppc", bp_pc, 32'h100);
        step(1);
        chk("rd_valid_hi", {31'd0, valid}, 32'd1);
        chk("rd_pc", d_pc, 32'h100);
        chk("rd_inst", d_inst, 32'hA500_0100);
        step(1);
        chk("rd_pc2", d_pc, 32'h104);

        // Asynchronous reset with two entries queued.
        ready = 1'b0;
        step(1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, valid}, 32'd0);
        chk("ar_stall", {31'd0, bp_stall}, 32'd1);
        chk("ar_bppc", bp_pc, 32'h0);
        chk("ar_rdaddr", {24'd0, ic_rdaddress}, 32'd0);
        chk("ar_d_pc", d_pc, 32'h0);
        step(1);

        // Restart: 2 fetches, 3 stalls, then 8 fetches with ready high.
        reset_n = 1'b1;
        step(2);
        chk("rs_valid", {31'd0, valid}, 32'd1);
        chk("rs_pc", d_pc, 32'h0);
        step(4);
        ready = 1'b1;
        step(8);
        chk("pc_head", d_pc, 32'h54);
`ifdef FETCH_PERF_CNT_EN
        exp_fc = 32'd10;
        exp_sc = 32'd3;
`else
        exp_fc = 32'd0;
        exp_sc = 32'd0;
`endif
        chk("fetch_count", fetch_count, exp_fc);
        chk("stall_count", stall_count, exp_sc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
